// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle RV32I datapath with a shared memory port.
// Decodes opcode/funct fields into mux selects, write enables and ALU ops.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_sel,
    output logic       ir_wren,
    output logic       pc_wren,
    output logic       regfile_wren,
    output logic       dmem_wren,
    output logic [1:0] ALU_asel,
    output logic [1:0] ALU_bsel,
    output logic [1:0] result_sel,
    output logic [1:0] ximm_sel,
    output logic [2:0] ALU_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;
    logic   alu_f3_ok, br_f3_ok, taken;
    logic   mem_req_c, ir_c, pc_c, rf_c, dm_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);
    assign br_f3_ok  = (funct3 != 3'b010) && (funct3 != 3'b011);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Z;
            3'b001:  taken = ~Z;
            3'b100:  taken = N ^ V;
            3'b101:  taken = ~(N ^ V);
            3'b110:  taken = ~C;
            3'b111:  taken = C;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ximm_sel = 2'b00;
        case (opcode)
            OP_SW:   ximm_sel = 2'b01;
            OP_BR:   ximm_sel = 2'b10;
            OP_JAL:  ximm_sel = 2'b11;
            default: ximm_sel = 2'b00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        ir_c        = 1'b0;
        pc_c        = 1'b0;
        rf_c        = 1'b0;
        dm_c        = 1'b0;
        adr_sel     = 1'b0;
        ALU_asel    = 2'b00;
        ALU_bsel    = 2'b00;
        result_sel  = 2'b00;
        ALU_control = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                ALU_bsel   = 2'b10;
                result_sel = 2'b10;
                if (mem_ready) begin
                    ir_c    = 1'b1;
                    pc_c    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // target precomputed into ALUout for a later branch
                ALU_asel = 2'b01;
                ALU_bsel = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:   state_d = alu_f3_ok ? S_EXECR : S_ILLEGAL;
                    OP_I:   state_d = alu_f3_ok ? S_EXECI : S_ILLEGAL;
                    OP_BR:  state_d = br_f3_ok ? S_BRANCH : S_ILLEGAL;
                    OP_JAL: state_d = S_JAL;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALU_asel = 2'b10;
                ALU_bsel = 2'b01;
                state_d  = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_sel   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_sel = 2'b01;
                rf_c       = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c = 1'b1;
                adr_sel   = 1'b1;
                if (mem_ready) begin
                    dm_c    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                ALU_asel = 2'b10;
                ALU_bsel = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                case (funct3)
                    3'b000: ALU_control =
                        (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALU_control = ALU_SLT;
                    3'b110:  ALU_control = ALU_OR;
                    3'b111:  ALU_control = ALU_AND;
                    default: ALU_control = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALU_asel    = 2'b10;
                ALU_control = ALU_SUB;
                pc_c        = taken;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                ALU_asel = 2'b01;
                ALU_bsel = 2'b10;
                pc_c     = 1'b1;
                state_d  = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase
    end

    // gating with rst_n drops every strobe the instant reset asserts
    assign mem_req      = mem_req_c & rst_n;
    assign ir_wren      = ir_c & rst_n;
    assign pc_wren      = pc_c & rst_n;
    assign regfile_wren = rf_c & rst_n;
    assign dmem_wren    = dm_c & rst_n;
    assign illegal      = (state_q == S_ILLEGAL);
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations are
// queued by the driver and checked by a monitor on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       N, Z, C, V;
    logic       mem_ready;
    logic       mem_req, adr_sel, ir_wren, pc_wren, regfile_wren, dmem_wren;
    logic [1:0] ALU_asel, ALU_bsel, result_sel, ximm_sel;
    logic [2:0] ALU_control;
    logic       illegal;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .N(N), .Z(Z), .C(C), .V(V),
        .mem_ready(mem_ready), .mem_req(mem_req), .adr_sel(adr_sel),
        .ir_wren(ir_wren), .pc_wren(pc_wren), .regfile_wren(regfile_wren),
        .dmem_wren(dmem_wren), .ALU_asel(ALU_asel), .ALU_bsel(ALU_bsel),
        .result_sel(result_sel), .ximm_sel(ximm_sel),
        .ALU_control(ALU_control), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] st;
        logic [5:0] en;
        int         al;
        int         rs;
        int         xs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // enable vector order: {mem_req, ir, pc, regfile, dmem, illegal}
    localparam logic [5:0] E0 = 6'b000000;
    localparam logic [5:0] EF = 6'b111000;
    localparam logic [5:0] EM = 6'b100000;
    localparam logic [5:0] EP = 6'b001000;
    localparam logic [5:0] ER = 6'b000100;
    localparam logic [5:0] ED = 6'b100010;
    localparam logic [5:0] EI = 6'b000001;

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        logic       bad;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {mem_req, ir_wren, pc_wren, regfile_wren,
                       dmem_wren, illegal};
                bad = (state !== e.st) || (act !== e.en);
                if (e.al >= 0 && ALU_control !== 3'(e.al)) bad = 1'b1;
                if (e.rs >= 0 && result_sel !== 2'(e.rs)) bad = 1'b1;
                if (e.xs >= 0 && ximm_sel !== 2'(e.xs)) bad = 1'b1;
                n_cmp++;
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d en=%b alu=%0d rs=%0d xs=%0d, want st=%0d en=%b alu=%0d rs=%0d xs=%0d",
                             e.nm, state, act, ALU_control, result_sel,
                             ximm_sel, e.st, e.en, e.al, e.rs, e.xs);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic rv, input logic mr,
                       input logic [3:0] st, input logic [5:0] en,
                       input int al = -1, input int rs = -1,
                       input int xs = -1);
        exp_t e;
        rst_n     = rv;
        mem_ready = mr;
        e.nm = nm; e.st = st; e.en = en; e.al = al; e.rs = rs; e.xs = xs;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7);
        opcode = op; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic flags(input logic n, input logic z, input logic c,
                         input logic v);
        N = n; Z = z; C = c; V = v;
    endtask

    task automatic branch(input string nm, input logic [2:0] f3,
                          input logic [5:0] en_br);
        instr(7'b1100011, f3, 1'b0);
        cyc({nm, "_f"}, 1, 1, 0, EF);
        cyc({nm, "_d"}, 1, 1, 1, E0, 0, -1, 2);
        cyc({nm, "_b"}, 1, 1, 9, en_br, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        instr(7'b0110011, 3'b000, 1'b1);
        flags(0, 0, 0, 0);
        @(posedge clk);
        #1;

        cyc("rst0", 0, 1, 0, E0);
        cyc("rst1", 0, 1, 0, E0);

        // R-type sub, zero wait
        cyc("sub_f", 1, 1, 0, EF, 0, 2);
        cyc("sub_d", 1, 1, 1, E0, 0);
        cyc("sub_x", 1, 1, 6, E0, 1);
        cyc("sub_w", 1, 1, 8, ER, -1, 0);

        // lw: 3 waits in FETCH, 2 in MEMREAD, 10 cycles total
        instr(7'b0000011, 3'b010, 1'b0);
        cyc("lw_f0", 1, 0, 0, EM);
        cyc("lw_f1", 1, 0, 0, EM);
        cyc("lw_f2", 1, 0, 0, EM);
        cyc("lw_f3", 1, 1, 0, EF);
        cyc("lw_d", 1, 1, 1, E0, 0, -1, 0);
        cyc("lw_a", 1, 1, 2, E0, 0);
        cyc("lw_r0", 1, 0, 3, EM);
        cyc("lw_r1", 1, 0, 3, EM);
        cyc("lw_r2", 1, 1, 3, EM);
        cyc("lw_wb", 1, 1, 4, ER, -1, 1);

        // sw with one wait in MEMWRITE
        instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_f", 1, 1, 0, EF);
        cyc("sw_d", 1, 1, 1, E0, -1, -1, 1);
        cyc("sw_a", 1, 1, 2, E0);
        cyc("sw_w0", 1, 0, 5, EM);
        cyc("sw_w1", 1, 1, 5, ED);

        // I-type ori and R-type and
        instr(7'b0010011, 3'b110, 1'b1);
        cyc("ori_f", 1, 1, 0, EF);
        cyc("ori_d", 1, 1, 1, E0);
        cyc("ori_x", 1, 1, 7, E0, 3);
        cyc("ori_w", 1, 1, 8, ER);
        instr(7'b0110011, 3'b111, 1'b0);
        cyc("and_f", 1, 1, 0, EF);
        cyc("and_d", 1, 1, 1, E0);
        cyc("and_x", 1, 1, 6, E0, 2);
        cyc("and_w", 1, 1, 8, ER);

        // branches
        flags(0, 1, 0, 0); branch("beq_z1", 3'b000, EP);
        flags(0, 1, 0, 0); branch("bne_z1", 3'b001, E0);
        flags(1, 0, 0, 0); branch("blt_n1", 3'b100, EP);
        flags(1, 0, 0, 1); branch("blt_nv", 3'b100, E0);
        flags(0, 0, 0, 0); branch("bgeu_c0", 3'b111, E0);
        flags(0, 0, 0, 0); branch("bltu_c0", 3'b110, EP);
        flags(0, 0, 0, 0);

        // jal
        instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_f", 1, 1, 0, EF);
        cyc("jal_d", 1, 1, 1, E0, -1, -1, 3);
        cyc("jal_j", 1, 1, 10, EP, 0, 0);
        cyc("jal_w", 1, 1, 8, ER, -1, 0);

        // async reset in the middle of MEMREAD
        instr(7'b0000011, 3'b010, 1'b0);
        cyc("mr_f", 1, 1, 0, EF);
        cyc("mr_d", 1, 1, 1, E0);
        cyc("mr_a", 1, 1, 2, E0);
        cyc("mr_r", 1, 0, 3, EM);
        cyc("mr_rst", 0, 0, 0, E0);
        cyc("mr_rel", 1, 0, 0, EM);
        cyc("mr_f2", 1, 1, 0, EF);
        cyc("mr_d2", 1, 1, 1, E0);
        cyc("mr_a2", 1, 1, 2, E0);
        cyc("mr_r2", 1, 1, 3, EM);
        cyc("mr_wb2", 1, 1, 4, ER);

        // jalr is illegal and sticky
        instr(7'b1100111, 3'b000, 1'b0);
        cyc("jalr_f", 1, 1, 0, EF);
        cyc("jalr_d", 1, 1, 1, E0);
        for (int i = 0; i < 20; i++) cyc("jalr_ill", 1, 1, 15, EI);
        cyc("ill_rst", 0, 1, 0, E0);

        // R-type funct3 001 is illegal
        instr(7'b0110011, 3'b001, 1'b0);
        cyc("r001_f", 1, 1, 0, EF);
        cyc("r001_d", 1, 1, 1, E0);
        cyc("r001_i0", 1, 1, 15, EI);
        cyc("r001_i1", 1, 0, 15, EI);
        cyc("r001_rst", 0, 1, 0, E0);
        cyc("after_rel", 1, 0, 0, EM);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for a multicycle RV32I datapath: one shared memory port, one ALU, plus IR, old-PC, A/B, ALUout and data registers.
- Decodes the opcode and sequences fetch, decode, execute, memory and writeback over several cycles, emitting mux selects and write enables.
- Stalls on a memory ready handshake and evaluates the full RV32I branch set from the ALU flags.

Parameters:
- None.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- funct7b5  in  1  instruction register bit 30.
- N,Z,C,V  in  1 each  ALU flags from the current-cycle ALU operation.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- adr_sel  out  1  memory address mux: 0 = PC, 1 = ALUout.
- ir_wren  out  1  load IR and old-PC.
- pc_wren  out  1  load PC from the result mux.
- regfile_wren  out  1  register file write enable.
- dmem_wren  out  1  memory write strobe.
- ALU_asel  out  2  ALU a input: 00 = PC, 01 = old-PC, 10 = reg A.
- ALU_bsel  out  2  ALU b input: 00 = reg B, 01 = immediate, 10 = constant 4.
- result_sel  out  2  result mux: 00 = ALUout, 01 = data reg, 10 = ALU direct.
- ximm_sel  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALU_control  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  4  current state, for debug.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- While rst_n = 0: state = FETCH; all enables forced 0 (mem_req, ir_wren, pc_wren, regfile_wren, dmem_wren); illegal = 0.
- Outputs are decoded from state, opcode and funct fields. Defaults unless a state sets them: enables 0, selects 0, ALU_control = add.
- ximm_sel is decoded from opcode in every state: lw/I-ALU -> I, sw -> S, branch -> B, jal -> J.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, ILLEGAL 15.
- FETCH:
  - mem_req = 1, adr_sel = 0, asel = PC, bsel = 4, add, result_sel = 10.
  - If mem_ready: ir_wren = 1, pc_wren = 1, go to DECODE. Otherwise hold FETCH with no writes.
- DECODE:
  - asel = old-PC, bsel = imm, add (precomputes branch target into ALUout).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other -> ILLEGAL.
  - R/I funct3 not in {000, 010, 110, 111} -> ILLEGAL.
  - Branch funct3 in {010, 011} -> ILLEGAL.
- MEMADR: asel = A, bsel = imm, add. Go to MEMREAD if opcode[5] = 0, else MEMWRITE.
- MEMREAD: mem_req = 1, adr_sel = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_sel = 01, regfile_wren = 1. Go to FETCH.
- MEMWRITE: mem_req = 1, adr_sel = 1. On mem_ready: dmem_wren = 1, go to FETCH. dmem_wren is never high without mem_ready.
- EXECR / EXECI:
  - asel = A; bsel = B (EXECR) or imm (EXECI). Go to ALUWB.
  - ALU_control by funct3: 000 -> add, or sub only when EXECR and funct7b5 = 1; 010 -> slt; 110 -> or; 111 -> and.
- ALUWB: result_sel = 00, regfile_wren = 1. Go to FETCH.
- BRANCH:
  - asel = A, bsel = B, sub, result_sel = 00.
  - pc_wren = taken, where by funct3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C.
  - Go to FETCH.
- JAL: asel = old-PC, bsel = 4, add, result_sel = 00, pc_wren = 1. Go to ALUWB, which writes the link value PC+4.
- ILLEGAL: illegal = 1; all enables 0; mem_req = 0. Remains here until reset.
- Boundary conditions:
  - mem_ready outside a mem_req state is ignored.
  - mem_ready held high gives the minimum latency.
  - Instruction latencies with zero wait states: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles.
  - Reset asserted mid-access drops mem_req immediately (asynchronously). The FSM restarts at FETCH on the first clk edge after rst_n rises.

Test Plan:
- Reset with rst_n = 0 mid-MEMREAD -> state = 0 and mem_req = 0 immediately; after release, FETCH with mem_req = 1.
- Zero-wait R-type sub (opcode 0110011, funct3 000, funct7b5 1) -> states 0,1,6,8,0; ALU_control = 001 in EXECR; regfile_wren high only in ALUWB.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD -> 10 cycles total; ir_wren and pc_wren pulse exactly once, on the ready cycle.
- Branches (Z, N, V, C combinations): beq Z = 1 -> pc_wren = 1; bne Z = 1 -> 0; blt N = 1, V = 0 -> 1; bgeu C = 0 -> 0; bltu C = 0 -> 1.
- jal -> states 0,1,10,8; pc_wren in JAL; regfile_wren in ALUWB with result_sel = 00.
- Opcode 1100111 (jalr), and R-type funct3 = 001 -> ILLEGAL (state 15), illegal = 1 sticky; no enables for 20 cycles; cleared only by reset.
